// File: rtl/te_pkg.sv
// ---------------------------------------------------------------------------
// te_pkg: shared types and constants for the transmission-estimation window
// scheduler (pixel width, FSM states, 3x3 window element indices).
// ---------------------------------------------------------------------------
package te_pkg;

   localparam int unsigned PIX_W = 8;
   localparam int unsigned WIN_N = 9;

   // Window element positions, row-major from the top-left neighbour
   localparam int unsigned WIN_P1 = 0;
   localparam int unsigned WIN_P2 = 1;
   localparam int unsigned WIN_P3 = 2;
   localparam int unsigned WIN_P4 = 3;
   localparam int unsigned WIN_P5 = 4;
   localparam int unsigned WIN_P6 = 5;
   localparam int unsigned WIN_P7 = 6;
   localparam int unsigned WIN_P8 = 7;
   localparam int unsigned WIN_P9 = 8;

   typedef logic [PIX_W-1:0] pix_t;
   typedef pix_t [WIN_N-1:0] win_t;
   typedef pix_t [2:0]       trip_t;   // one column: top, mid, bottom row

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      RUN,
      EOL,
      FLUSH,
      DONE
   } state_t;

endpackage

// File: rtl/te_window_scheduler_if.sv
// ---------------------------------------------------------------------------
// te_window_scheduler_if: pixel-in / window-out bundle of the scheduler.
//   master : the scheduler (accepts pixels, drives windows and status)
//   slave  : the environment (pixel source, window sink, control)
// Signals: frame_start, in_pixel/in_valid/in_ready, win_p1..win_p9,
//   win_valid/win_ready, win_row, win_col, win_last, busy, frame_done.
// With TE_EDGE_STATS_EN defined: est_w_center (in), edge_count (out).
// ---------------------------------------------------------------------------
interface te_window_scheduler_if #(
   parameter int unsigned WIDTH  = 640,
   parameter int unsigned HEIGHT = 480,
   parameter int unsigned CNT_W  = 20
);
   import te_pkg::*;

   localparam int unsigned COL_W = $clog2(WIDTH);
   localparam int unsigned ROW_W = $clog2(HEIGHT);

   logic             frame_start;
   pix_t             in_pixel;
   logic             in_valid;
   logic             in_ready;
   pix_t             win_p1, win_p2, win_p3;
   pix_t             win_p4, win_p5, win_p6;
   pix_t             win_p7, win_p8, win_p9;
   logic             win_valid;
   logic             win_ready;
   logic [ROW_W-1:0] win_row;
   logic [COL_W-1:0] win_col;
   logic             win_last;
   logic             busy;
   logic             frame_done;
`ifdef TE_EDGE_STATS_EN
   logic             est_w_center;
   logic [CNT_W-1:0] edge_count;
`endif

   modport master (
      input  frame_start, in_pixel, in_valid, win_ready,
`ifdef TE_EDGE_STATS_EN
      input  est_w_center,
      output edge_count,
`endif
      output in_ready, win_p1, win_p2, win_p3, win_p4, win_p5, win_p6,
             win_p7, win_p8, win_p9, win_valid, win_row, win_col,
             win_last, busy, frame_done
   );

   modport slave (
      output frame_start, in_pixel, in_valid, win_ready,
`ifdef TE_EDGE_STATS_EN
      output est_w_center,
      input  edge_count,
`endif
      input  in_ready, win_p1, win_p2, win_p3, win_p4, win_p5, win_p6,
             win_p7, win_p8, win_p9, win_valid, win_row, win_col,
             win_last, busy, frame_done
   );

endinterface

// File: rtl/te_line_buffer.sv
// ---------------------------------------------------------------------------
// te_line_buffer: one image row, single write port, registered read port.
// Ports: clk, i_we/i_waddr/i_wdata (write), i_raddr -> o_rdata (1-cycle read).
// Contents are not reset.
// ---------------------------------------------------------------------------
module te_line_buffer
   import te_pkg::*;
#(
   parameter int unsigned WIDTH  = 640,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  pix_t              i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output pix_t              o_rdata
);

   pix_t r_mem [WIDTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/te_window_scheduler.sv
// ---------------------------------------------------------------------------
// te_window_scheduler: turns a raster pixel stream into 3x3 border-replicated
// windows in raster order, one register stage on the window output.
// Ports: clk, rst (sync, active high), bus (te_window_scheduler_if.master).
// Optional: TE_EDGE_STATS_EN adds est_w_center / edge_count on the bus.
// ---------------------------------------------------------------------------
module te_window_scheduler
   import te_pkg::*;
#(
   parameter int unsigned WIDTH  = 640,
   parameter int unsigned HEIGHT = 480,
   parameter int unsigned CNT_W  = 20
) (
   input  logic                   clk,
   input  logic                   rst,
   te_window_scheduler_if.master  bus
);

   localparam int unsigned      COL_W      = $clog2(WIDTH);
   localparam int unsigned      ROW_W      = $clog2(HEIGHT);
   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_PENULT = ROW_W'(HEIGHT - 2);

   state_t           r_state, w_state_nxt;
   logic [COL_W-1:0] r_col, w_raddr;
   logic [ROW_W-1:0] r_row;
   logic             r_tail;
   trip_t            r_prev1, r_prev2, w_cur;
   win_t             r_win, w_win;
   logic             r_win_valid, r_win_last;
   logic [ROW_W-1:0] r_win_row;
   logic [COL_W-1:0] r_win_col, w_win_col;
   logic             r_busy, r_frame_done;
   pix_t             w_top_rd, w_mid_rd, w_top_wdata;
   logic             w_out_free, w_in_ready, w_accept, w_shift;
   logic             w_emit, w_emit_last, w_tail_win;

   // Row r-1 (top) is fed from row r (mid) as each column is consumed
   te_line_buffer #(.WIDTH(WIDTH), .ADDR_W(COL_W)) u_top (
      .clk(clk), .i_we(w_accept), .i_waddr(r_col), .i_wdata(w_top_wdata),
      .i_raddr(w_raddr), .o_rdata(w_top_rd));

   te_line_buffer #(.WIDTH(WIDTH), .ADDR_W(COL_W)) u_mid (
      .clk(clk), .i_we(w_accept), .i_waddr(r_col), .i_wdata(bus.in_pixel),
      .i_raddr(w_raddr), .o_rdata(w_mid_rd));

   // Row 0 goes into both buffers so the top neighbour of row 0 replicates it
   assign w_top_wdata = (r_state == PRIME) ? bus.in_pixel : w_mid_rd;
   assign w_accept    = w_in_ready && bus.in_valid;
   // Prefetch the column that will be consumed next
   assign w_raddr     = (w_accept || w_shift) ?
                        ((r_col == COL_LAST) ? '0 : r_col + COL_W'(1)) : r_col;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state, pixel acceptance and window-emission decode
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_shift     = 1'b0;
      w_emit      = 1'b0;
      w_emit_last = 1'b0;
      w_tail_win  = 1'b0;
      w_out_free  = !r_win_valid || bus.win_ready;
      unique case (r_state)
         IDLE:  if (bus.frame_start) w_state_nxt = PRIME;
         PRIME: begin
            w_in_ready = w_out_free;
            if (bus.in_valid && w_out_free && r_col == COL_LAST) w_state_nxt = RUN;
         end
         RUN: begin
            w_in_ready = w_out_free;
            if (bus.in_valid && w_out_free) begin
               w_shift = 1'b1;
               w_emit  = (r_col != '0);
               if (r_col == COL_LAST) w_state_nxt = EOL;
            end
         end
         EOL: if (w_out_free) begin
            w_emit      = 1'b1;
            w_tail_win  = 1'b1;
            w_state_nxt = (r_row == ROW_PENULT) ? FLUSH : RUN;
         end
         FLUSH: begin
            // Last window out: wait for its handshake before finishing
            if (r_win_last) begin
               if (bus.win_ready) w_state_nxt = DONE;
            end else if (w_out_free) begin
               if (r_tail) begin
                  w_emit      = 1'b1;
                  w_tail_win  = 1'b1;
                  w_emit_last = 1'b1;
               end else begin
                  w_shift = 1'b1;
                  w_emit  = (r_col != '0);
               end
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Window assembly; left column clamps at col 0, right column at the row end
   always_comb begin
      w_cur     = '0;
      w_win     = '0;
      w_cur[0]  = w_top_rd;
      w_cur[1]  = w_mid_rd;
      w_cur[2]  = (r_state == FLUSH) ? w_mid_rd : bus.in_pixel;
      w_win_col = w_tail_win ? COL_LAST : r_col - COL_W'(1);
      for (int k = 0; k < 3; k++) begin
         w_win[WIN_P1 + 3*k] = (!w_tail_win && r_col == COL_W'(1)) ? r_prev1[k] : r_prev2[k];
         w_win[WIN_P2 + 3*k] = r_prev1[k];
         w_win[WIN_P3 + 3*k] = w_tail_win ? r_prev1[k] : w_cur[k];
      end
   end

   // Counters, column history and the output register stage
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col        <= '0;
         r_row        <= '0;
         r_tail       <= 1'b0;
         r_prev1      <= '0;
         r_prev2      <= '0;
         r_win        <= '0;
         r_win_valid  <= 1'b0;
         r_win_last   <= 1'b0;
         r_win_row    <= '0;
         r_win_col    <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         if (w_accept || w_shift)
            r_col <= (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
         if (w_shift) begin
            r_prev2 <= r_prev1;
            r_prev1 <= w_cur;
         end
         if (r_state == EOL && w_out_free) r_row <= r_row + ROW_W'(1);
         else if (r_state == DONE)         r_row <= '0;
         if (r_state == FLUSH && w_shift && r_col == COL_LAST) r_tail <= 1'b1;
         else if (w_emit_last || r_state == DONE)              r_tail <= 1'b0;
         if (w_out_free) begin
            r_win_valid <= w_emit;
            r_win_last  <= w_emit_last;
            if (w_emit) begin
               r_win     <= w_win;
               r_win_row <= r_row;
               r_win_col <= w_win_col;
            end
         end
         r_busy       <= (w_state_nxt != IDLE);
         r_frame_done <= (w_state_nxt == DONE);
      end
   end

`ifdef TE_EDGE_STATS_EN
   logic [CNT_W-1:0] r_edge_count;

   // Edge statistics: cleared by an accepted frame_start, saturating
   always_ff @(posedge clk) begin
      if (rst)
         r_edge_count <= '0;
      else if (r_state == IDLE && bus.frame_start)
         r_edge_count <= '0;
      else if (r_win_valid && bus.win_ready && bus.est_w_center && r_edge_count != '1)
         r_edge_count <= r_edge_count + CNT_W'(1);
   end

   assign bus.edge_count = r_edge_count;
`endif

   assign bus.in_ready   = w_in_ready;
   assign bus.win_p1     = r_win[WIN_P1];
   assign bus.win_p2     = r_win[WIN_P2];
   assign bus.win_p3     = r_win[WIN_P3];
   assign bus.win_p4     = r_win[WIN_P4];
   assign bus.win_p5     = r_win[WIN_P5];
   assign bus.win_p6     = r_win[WIN_P6];
   assign bus.win_p7     = r_win[WIN_P7];
   assign bus.win_p8     = r_win[WIN_P8];
   assign bus.win_p9     = r_win[WIN_P9];
   assign bus.win_valid  = r_win_valid;
   assign bus.win_row    = r_win_row;
   assign bus.win_col    = r_win_col;
   assign bus.win_last   = r_win_last;
   assign bus.busy       = r_busy;
   assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_te_window_scheduler.sv
// ---------------------------------------------------------------------------
// tb_te_window_scheduler: directed bench for te_window_scheduler on a 4x3
// frame with pixel value 10*row+col.
// ---------------------------------------------------------------------------
module tb_te_window_scheduler;
   import te_pkg::*;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int CW = 20;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   te_window_scheduler_if #(.WIDTH(W), .HEIGHT(H), .CNT_W(CW)) bus ();
   te_window_scheduler #(.WIDTH(W), .HEIGHT(H), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   int             n_checks = 0;
   int             n_errors = 0;
   int             pix_idx, nwin, done_pulses, rdy_mode;
   bit             stalled_prev, expect_done;
   logic [95:0]    snap;
   logic [95:0]    got_q [$];

   task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pix(input int r, input int c);
      return 8'(10 * r + c);
   endfunction

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   // {last, row, col, p1..p9}
   function automatic logic [95:0] exp_win(input int r, input int c, input bit last);
      logic [95:0] v;
      v = {7'b0, last, 4'(r), 4'(c), 72'b0};
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            v[71 - 8*((dr+1)*3 + (dc+1)) -: 8] = pix(clampi(r+dr, H-1), clampi(c+dc, W-1));
      return v;
   endfunction

   function automatic logic [95:0] obs_win();
      return {7'b0, bus.win_last, 4'(bus.win_row), 4'(bus.win_col),
              bus.win_p1, bus.win_p2, bus.win_p3, bus.win_p4, bus.win_p5,
              bus.win_p6, bus.win_p7, bus.win_p8, bus.win_p9};
   endfunction

   // One clock: drive at the falling edge, observe 1 time unit later
   task automatic step(input bit want_valid);
      @(negedge clk);
      bus.win_ready = (rdy_mode == 0) ? 1'b1 : ~bus.win_ready;
      bus.in_valid  = want_valid && (pix_idx < W*H);
      bus.in_pixel  = pix(pix_idx / W, pix_idx % W);
      #1;
      if (stalled_prev) check_eq("stall_hold", obs_win(), snap);
      if (expect_done) begin
         check_eq("frame_done_after_last", 96'(bus.frame_done), 96'd1);
         expect_done = 1'b0;
      end
      if (bus.frame_done) done_pulses++;
      stalled_prev = bus.win_valid && !bus.win_ready;
      if (stalled_prev) begin
         snap = obs_win();
         check_eq("stall_in_ready", 96'(bus.in_ready), 96'd0);
      end
`ifdef TE_EDGE_STATS_EN
      bus.est_w_center = bus.win_valid && (nwin % 3 == 2);
`endif
      if (bus.win_valid && bus.win_ready) begin
         got_q.push_back(obs_win());
         nwin++;
         if (bus.win_last) expect_done = 1'b1;
      end
      if (bus.in_valid && bus.in_ready) pix_idx++;
   endtask

   task automatic start_frame();
      pix_idx = 0; nwin = 0; done_pulses = 0;
      stalled_prev = 1'b0; expect_done = 1'b0;
      got_q.delete();
      @(negedge clk);
      bus.frame_start = 1'b1;
      bus.in_valid    = 1'b0;
      @(negedge clk);
      bus.frame_start = 1'b0;
      #1;
      check_eq("busy_after_start", 96'(bus.busy), 96'd1);
   endtask

   task automatic run_frame(input string name, input int mode, input int gap_at, input bit fs_mid);
      int  cyc, gap_cnt;
      bit  in_gap;
      rdy_mode = mode;
      bus.win_ready = 1'b0;
      start_frame();
      cyc = 0; gap_cnt = 0;
      while (done_pulses == 0 && cyc < 300) begin
         in_gap = (gap_at >= 0) && (pix_idx == gap_at) && (gap_cnt < 5);
         bus.frame_start = fs_mid && (cyc == 3 || cyc == 12);
         step(!in_gap);
         if (in_gap) begin
            if (gap_cnt >= 1) check_eq({name, "_gap_no_win"}, 96'(bus.win_valid), 96'd0);
            gap_cnt++;
         end
         cyc++;
      end
      bus.frame_start = 1'b0;
      step(1'b0);
      step(1'b0);
      check_eq({name, "_done_pulses"}, 96'(done_pulses), 96'd1);
      check_eq({name, "_idle_busy"},   96'(bus.busy), 96'd0);
      check_eq({name, "_win_count"},   96'(got_q.size()), 96'(W*H));
      for (int i = 0; i < W*H && i < got_q.size(); i++)
         check_eq($sformatf("%s_win%0d", name, i), got_q[i], exp_win(i / W, i % W, i == W*H-1));
   endtask

   task automatic check_reset(input string name);
      check_eq({name, "_win_valid"},  96'(bus.win_valid), 96'd0);
      check_eq({name, "_in_ready"},   96'(bus.in_ready), 96'd0);
      check_eq({name, "_busy"},       96'(bus.busy), 96'd0);
      check_eq({name, "_frame_done"}, 96'(bus.frame_done), 96'd0);
      check_eq({name, "_window"},     obs_win(), 96'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.frame_start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int cyc;
      rst = 1'b1;
      bus.frame_start = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_pixel    = '0;
      bus.win_ready   = 1'b0;
`ifdef TE_EDGE_STATS_EN
      bus.est_w_center = 1'b0;
`endif
      rdy_mode = 0;
      do_reset();
      check_reset("reset");

      // Plain frame, with hand-computed corner windows
      run_frame("basic", 0, -1, 1'b0);
      if (got_q.size() == W*H) begin
         check_eq("win_0_0_hand", got_q[0],
            {7'b0, 1'b0, 4'd0, 4'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd10, 8'd10, 8'd11});
         check_eq("win_2_3_hand", got_q[W*H-1],
            {7'b0, 1'b1, 4'd2, 4'd3, 8'd12, 8'd13, 8'd13, 8'd22, 8'd23, 8'd23, 8'd22, 8'd23, 8'd23});
      end
`ifdef TE_EDGE_STATS_EN
      check_eq("edge_count_hold", 96'(bus.edge_count), 96'd4);
      @(negedge clk);
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
      #1;
      check_eq("edge_count_clear", 96'(bus.edge_count), 96'd0);
      do_reset();
`endif

      // Downstream toggling ready
      run_frame("stall", 1, -1, 1'b0);

      // Source gap of 5 cycles before pixel (1,2)
      run_frame("gap", 0, 6, 1'b0);

      // Reset in the middle of row 1, then a clean frame
      rdy_mode = 0;
      start_frame();
      cyc = 0;
      while (pix_idx < 6 && cyc < 100) begin
         step(1'b1);
         cyc++;
      end
      check_eq("mid_reset_reached", 96'(pix_idx), 96'd6);
      do_reset();
      check_reset("mid_reset");
      run_frame("after_reset", 0, -1, 1'b0);

      // frame_start pulses while busy are ignored
      run_frame("fs_busy", 0, -1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/te_window_scheduler.md
Name: te_window_scheduler

Overview:
Sequences a raster 8-bit pixel stream into 3x3 neighbourhood windows for the transmission-estimation edge/filter-weight stage. Two internal line buffers hold the previous rows, and a state machine replicates pixels at the image borders. Windows are issued with a valid/ready handshake, and the block back-pressures the pixel source whenever it must emit without consuming input. It sits between the pixel input FIFO and the filter-weight estimator.

Parameters:
WIDTH, 640, pixels per row (>=3)
HEIGHT, 480, rows per frame (>=2)
CNT_W, 20, edge-statistics counter width (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse; accepted only in IDLE
in_pixel  in  8  raster pixel
in_valid  in  1  source has a pixel
in_ready  out  1  pixel accepted when in_valid && in_ready
win_p1..win_p9  out  8 each  window: p1 top-left, p2 top, p3 top-right, p4 left, p5 centre, p6 right, p7..p9 bottom row
win_valid  out  1  window valid
win_ready  in  1  downstream accepts
win_row  out  log2(HEIGHT)  centre row
win_col  out  log2(WIDTH)  centre column
win_last  out  1  final window of the frame
busy  out  1  high outside IDLE
frame_done  out  1  one-cycle pulse after the last window handshake

Behaviour:
- Reset, or rst asserted mid-frame: state IDLE; all counters 0; win_valid, in_ready, busy, frame_done, win_last all 0; window registers 0. Line-buffer contents are don't-care.
- Neighbour addressing: the neighbour (r+dr, c+dc) is clamped to [0,HEIGHT-1] x [0,WIDTH-1] (border replication).
- Output is a single register stage: win_valid rises the cycle after the triggering event. While win_valid && !win_ready, all win_* outputs hold and in_ready=0.
- in_ready = (state in PRIME or RUN) && (!win_valid || win_ready).
- IDLE: on frame_start go to PRIME. frame_start outside IDLE is ignored.
- PRIME: accepts row 0 (WIDTH pixels) into the line buffer. No windows are emitted. Then go to RUN with r=0.
- RUN: accepting pixel (r+1, j) with j>=1 emits window (r, j-1). Accepting j=0 emits nothing. After j=WIDTH-1, go to EOL.
- EOL: one cycle with in_ready=0. Emits window (r, WIDTH-1). Then r++. If r+1==HEIGHT, go to FLUSH; else return to RUN.
- FLUSH: in_ready=0. Emits row HEIGHT-1 windows for columns 0..WIDTH-1 at one per handshake; the bottom row replicates the centre row. win_last=1 on column WIDTH-1. After its handshake go to DONE.
- DONE: frame_done=1 for one cycle, then IDLE.
- Counters wrap to 0 at WIDTH-1 and HEIGHT-1 respectively.
- Throughput is 1 window/cycle while unstalled. Windows per frame = WIDTH*HEIGHT, in strict raster order.
- Line buffers are written on accept only. The read of column j+1 is pipelined so the window registers never read a stale value.

Optional Feature:
TE_EDGE_STATS_EN
- Defined: adds input est_w_center (1 bit, combinational from the estimator for the current window) and output edge_count [CNT_W-1:0].
  - edge_count clears on the accepted frame_start.
  - It increments on win_valid && win_ready && est_w_center and saturates at all-ones.
  - It holds its value after frame_done.
- Undefined: neither port exists and no counter logic is present.

Decomposition:
- Shared package te_pkg: PIX_W=8, the state enum (IDLE, PRIME, RUN, EOL, FLUSH, DONE) and the window-index constants.
- Sub-module te_line_buffer: a WIDTH x 8 single-write, registered-read row store, instantiated twice (row r-1 and row r).

Test Plan:
- 4x3 frame, pixel value = 10*row+col, no stalls:
  - 12 windows in raster order.
  - Window (0,0) = p1..p9 {0,0,1,0,0,1,10,10,11}.
  - Window (2,3) = {12,13,13,22,23,23,22,23,23}.
  - win_last only on (2,3); frame_done the cycle after.
- Same frame with win_ready toggling 1-0-1-0: outputs stable while stalled, in_ready=0 during stalls, identical window sequence.
- in_valid deasserted for 5 cycles mid-row 1: no windows emitted in the gap; sequence unchanged.
- rst pulsed during RUN at pixel (1,2), then a new frame_start: clean frame with correct (0,0) window, no residue from the prior frame.
- frame_start pulsed while busy: ignored; frame count and windows unaffected.
- TE_EDGE_STATS_EN, est_w_center forced 1 on every third window of the 4x3 frame: edge_count=4 after frame_done, cleared to 0 on the next frame_start.
